// File: rtl/bus_route_sequencer_if.sv
// Handshake and bus-selector bundle between the decoder-side requester and the route sequencer.
interface bus_route_sequencer_if #(
    parameter int SELECTOR_WIDTH = 4
);
    logic                      req_valid;
    logic [SELECTOR_WIDTH-1:0] req_src;
    logic [SELECTOR_WIDTH-1:0] req_dst;
    logic                      req_ready;
    logic                      stall;
    logic [SELECTOR_WIDTH-1:0] pc_selector;
    logic [SELECTOR_WIDTH-1:0] sp_selector;
    logic [SELECTOR_WIDTH-1:0] add_selector;
    logic [SELECTOR_WIDTH-1:0] x_selector;
    logic [SELECTOR_WIDTH-1:0] y_selector;
    logic [SELECTOR_WIDTH-1:0] stat_selector;
    logic [SELECTOR_WIDTH-1:0] mem_selector;
    logic [SELECTOR_WIDTH-1:0] fetch_selector;
    logic [SELECTOR_WIDTH-1:0] decode_selector;
    logic [SELECTOR_WIDTH-1:0] alu0_selector;
    logic [SELECTOR_WIDTH-1:0] alu1_selector;
    logic [10:0]               dst_we;
    logic                      done;
    logic                      err;
    logic                      busy;

    modport master (
        output req_valid, req_src, req_dst, stall,
        input  req_ready, pc_selector, sp_selector, add_selector, x_selector, y_selector,
               stat_selector, mem_selector, fetch_selector, decode_selector,
               alu0_selector, alu1_selector, dst_we, done, err, busy
    );

    modport slave (
        input  req_valid, req_src, req_dst, stall,
        output req_ready, pc_selector, sp_selector, add_selector, x_selector, y_selector,
               stat_selector, mem_selector, fetch_selector, decode_selector,
               alu0_selector, alu1_selector, dst_we, done, err, busy
    );
endinterface

// File: rtl/bus_route_sequencer.sv
// Queues {src, dst} transfer micro-ops and walks each through drive / wait / commit on the bus mux fabric.
module bus_route_sequencer #(
    parameter int DEPTH          = 4,
    parameter int SELECTOR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_route_sequencer_if.slave  bus
);
    localparam int SW   = SELECTOR_WIDTH;
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NDST = 11;

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT, COMMIT} state_t;

    state_t          state_q, state_d;
    logic [2*SW-1:0] fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [SW-1:0]   sel_q [NDST];
    logic [NDST-1:0] we_q;
    logic            err_q;

    logic            legal, push, pop, empty, ready;
    logic [SW-1:0]   head_src, head_dst;

    assign legal    = (int'(bus.req_src) < 12) && (int'(bus.req_dst) < NDST);
    assign ready    = (int'(count) < DEPTH);
    assign empty    = (count == '0);
    assign push     = bus.req_valid && ready && legal;
    assign head_src = fifo_mem[rd_ptr][2*SW-1:SW];
    assign head_dst = fifo_mem[rd_ptr][SW-1:0];

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.stall && !empty) begin
                    pop     = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE:  if (!bus.stall) state_d = WAIT;
            WAIT:   if (!bus.stall) state_d = COMMIT;
            COMMIT: begin
                if (!bus.stall) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = DRIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Queue storage carries no reset; pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {bus.req_src, bus.req_dst};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_q   <= 1'b0;
            we_q    <= '0;
            for (int d = 0; d < NDST; d++) sel_q[d] <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= bus.req_valid && ready && !legal;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Popping rewrites every selector, so a reused destination simply takes the new source.
            if (pop) begin
                for (int d = 0; d < NDST; d++)
                    sel_q[d] <= (int'(head_dst) == d) ? head_src : '0;
                we_q <= NDST'(1) << head_dst;
            end else if (state_q == COMMIT && !bus.stall) begin
                for (int d = 0; d < NDST; d++) sel_q[d] <= '0;
                we_q <= '0;
            end
        end
    end

    // Write enable is suppressed for every stalled COMMIT cycle so exactly one pulse escapes.
    assign bus.dst_we = (state_q == COMMIT && !bus.stall) ? we_q : '0;
    assign bus.done   = (state_q == COMMIT) && !bus.stall;
    assign bus.err    = err_q;
    assign bus.busy   = (state_q != IDLE) || !empty;
    assign bus.req_ready = ready;

    assign bus.pc_selector     = sel_q[0];
    assign bus.sp_selector     = sel_q[1];
    assign bus.add_selector    = sel_q[2];
    assign bus.x_selector      = sel_q[3];
    assign bus.y_selector      = sel_q[4];
    assign bus.stat_selector   = sel_q[5];
    assign bus.mem_selector    = sel_q[6];
    assign bus.fetch_selector  = sel_q[7];
    assign bus.decode_selector = sel_q[8];
    assign bus.alu0_selector   = sel_q[9];
    assign bus.alu1_selector   = sel_q[10];
endmodule

// File: tb/tb_bus_route_sequencer.sv
// Directed bench for bus_route_sequencer: reset, single transfer, full queue, illegal ops, commit stall, reset mid-transfer.
module tb_bus_route_sequencer;
    logic clk;
    logic reset;
    int   n_run;
    int   n_fail;

    bus_route_sequencer_if #(.SELECTOR_WIDTH(4)) bif ();

    bus_route_sequencer #(.DEPTH(4), .SELECTOR_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [43:0] sels();
        return {bif.pc_selector, bif.sp_selector, bif.add_selector, bif.x_selector,
                bif.y_selector, bif.stat_selector, bif.mem_selector, bif.fetch_selector,
                bif.decode_selector, bif.alu0_selector, bif.alu1_selector};
    endfunction

    // Expected selector vector with only destination idx carrying val (pc is idx 0, leftmost).
    function automatic logic [43:0] one_sel(input int idx, input int val);
        logic [43:0] v;
        v = 44'(val);
        return v << (4 * (10 - idx));
    endfunction

    function automatic logic [10:0] we_bit(input int idx);
        logic [10:0] v;
        v = 11'd1;
        return v << idx;
    endfunction

    task automatic push_req(input int src, input int dst);
        bif.req_valid = 1'b1;
        bif.req_src   = 4'(src);
        bif.req_dst   = 4'(dst);
    endtask

    int srcs [5] = '{1, 2, 3, 5, 6};
    int dsts [5] = '{1, 2, 3, 4, 5};

    initial begin
        n_run         = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bif.req_valid = 1'b0;
        bif.req_src   = '0;
        bif.req_dst   = '0;
        bif.stall     = 1'b0;
        step();
        step();
        chk("rst_sels",   64'(sels()),        64'd0);
        chk("rst_we",     64'(bif.dst_we),    64'd0);
        chk("rst_done",   64'(bif.done),      64'd0);
        chk("rst_err",    64'(bif.err),       64'd0);
        chk("rst_busy",   64'(bif.busy),      64'd0);
        chk("rst_ready",  64'(bif.req_ready), 64'd1);
        reset = 1'b0;

        // Single transfer x -> pc
        push_req(4, 0);
        step();
        bif.req_valid = 1'b0;
        chk("s_c0_busy", 64'(bif.busy),   64'd1);
        chk("s_c0_sels", 64'(sels()),     64'd0);
        step();
        chk("s_c1_sels", 64'(sels()),     64'(one_sel(0, 4)));
        chk("s_c1_we",   64'(bif.dst_we), 64'd0);
        step();
        chk("s_c2_sels", 64'(sels()),     64'(one_sel(0, 4)));
        chk("s_c2_done", 64'(bif.done),   64'd0);
        step();
        chk("s_c3_sels", 64'(sels()),     64'(one_sel(0, 4)));
        chk("s_c3_we",   64'(bif.dst_we), 64'(11'b000_0000_0001));
        chk("s_c3_done", 64'(bif.done),   64'd1);
        step();
        chk("s_c4_sels", 64'(sels()),     64'd0);
        chk("s_c4_we",   64'(bif.dst_we), 64'd0);
        chk("s_c4_done", 64'(bif.done),   64'd0);
        chk("s_c4_busy", 64'(bif.busy),   64'd0);

        // Illegal src then illegal dst
        push_req(13, 0);
        step();
        chk("ill_src_err",  64'(bif.err),  64'd1);
        chk("ill_src_busy", 64'(bif.busy), 64'd0);
        push_req(0, 11);
        step();
        bif.req_valid = 1'b0;
        chk("ill_dst_err",  64'(bif.err),  64'd1);
        chk("ill_dst_busy", 64'(bif.busy), 64'd0);
        step();
        chk("ill_err_clr",  64'(bif.err),       64'd0);
        chk("ill_ready",    64'(bif.req_ready), 64'd1);
        step();
        chk("ill_no_we",    64'(bif.dst_we),    64'd0);
        chk("ill_busy",     64'(bif.busy),      64'd0);

        // Fill the queue while stalled, then drain back-to-back
        bif.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_req(srcs[i], dsts[i]);
            step();
        end
        chk("full_ready", 64'(bif.req_ready), 64'd0);
        chk("full_busy",  64'(bif.busy),      64'd1);
        push_req(srcs[4], dsts[4]);
        step();
        chk("full_hold_ready", 64'(bif.req_ready), 64'd0);
        chk("full_hold_sels",  64'(sels()),        64'd0);
        bif.stall = 1'b0;
        step();
        chk("bb_e1_sels",  64'(sels()),        64'(one_sel(dsts[0], srcs[0])));
        chk("bb_e1_ready", 64'(bif.req_ready), 64'd1);
        step();
        bif.req_valid = 1'b0;
        chk("bb_e5_in_ready", 64'(bif.req_ready), 64'd0);
        chk("bb_e1_wait_we",  64'(bif.dst_we),    64'd0);
        step();
        chk("bb_e1_we",   64'(bif.dst_we), 64'(we_bit(dsts[0])));
        chk("bb_e1_done", 64'(bif.done),   64'd1);
        for (int i = 1; i < 5; i++) begin
            step();
            chk("bb_drive_we",   64'(bif.dst_we), 64'd0);
            chk("bb_drive_sels", 64'(sels()),     64'(one_sel(dsts[i], srcs[i])));
            step();
            chk("bb_wait_done",  64'(bif.done),   64'd0);
            step();
            chk("bb_commit_we",   64'(bif.dst_we), 64'(we_bit(dsts[i])));
            chk("bb_commit_done", 64'(bif.done),   64'd1);
        end
        step();
        chk("bb_end_busy", 64'(bif.busy),   64'd0);
        chk("bb_end_sels", 64'(sels()),     64'd0);
        chk("bb_end_we",   64'(bif.dst_we), 64'd0);

        // Stall held across four COMMIT cycles
        push_req(11, 9);
        step();
        bif.req_valid = 1'b0;
        step();
        step();
        step();
        bif.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stc_we",   64'(bif.dst_we), 64'd0);
            chk("stc_done", 64'(bif.done),   64'd0);
            chk("stc_sels", 64'(sels()),     64'(one_sel(9, 11)));
            step();
        end
        bif.stall = 1'b0;
        #1;
        chk("stc_rel_we",   64'(bif.dst_we), 64'(we_bit(9)));
        chk("stc_rel_done", 64'(bif.done),   64'd1);
        chk("stc_rel_sels", 64'(sels()),     64'(one_sel(9, 11)));
        step();
        chk("stc_after_we",   64'(bif.dst_we), 64'd0);
        chk("stc_after_sels", 64'(sels()),     64'd0);
        chk("stc_after_busy", 64'(bif.busy),   64'd0);

        // Reset during WAIT with two entries queued
        push_req(7, 6);
        step();
        push_req(1, 0);
        step();
        push_req(2, 1);
        step();
        bif.req_valid = 1'b0;
        chk("rw_wait_sels", 64'(sels()),   64'(one_sel(6, 7)));
        chk("rw_wait_busy", 64'(bif.busy), 64'd1);
        reset = 1'b1;
        push_req(3, 3);
        step();
        chk("rw_r1_sels",  64'(sels()),        64'd0);
        chk("rw_r1_we",    64'(bif.dst_we),    64'd0);
        chk("rw_r1_busy",  64'(bif.busy),      64'd0);
        chk("rw_r1_ready", 64'(bif.req_ready), 64'd1);
        step();
        reset = 1'b0;
        bif.req_valid = 1'b0;
        chk("rw_r2_sels", 64'(sels()),     64'd0);
        chk("rw_r2_busy", 64'(bif.busy),   64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rw_post_we",   64'(bif.dst_we), 64'd0);
            chk("rw_post_busy", 64'(bif.busy),   64'd0);
            chk("rw_post_sels", 64'(sels()),     64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_route_sequencer.md
# bus_route_sequencer

Sequences register-to-register transfers across the CPU data bus mux fabric. It accepts queued transfer micro-ops (source code, destination index) from the decode/control logic and drives the eleven 4-bit bus selectors. It holds each route stable across the clocked mux latency, then pulses a one-hot destination write enable. Sits between the decoder and the data bus; it is the only driver of the bus selector inputs.

## Interface

- DEPTH, 4: transfer queue depth in entries (power of two, 2..16).
- SELECTOR_WIDTH, 4: width of each bus selector and of the source code.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  transfer request present.
- req_src  in  4  source code: 0 zero, 1 pc, 2 sp, 3 add, 4 x, 5 y, 6 stat, 7 mem, 8 imm, 9 fetch, 10 decode, 11 alu; 12–15 illegal.
- req_dst  in  4  destination index: 0 pc, 1 sp, 2 add, 3 x, 4 y, 5 stat, 6 mem, 7 fetch, 8 decode, 9 alu0, 10 alu1; 11–15 illegal.
- req_ready  out  1  queue can accept; equals (count < DEPTH), registered-state derived.
- stall  in  1  freeze sequencing; holds current state.
- pc_selector, sp_selector, add_selector, x_selector, y_selector, stat_selector, mem_selector, fetch_selector, decode_selector, alu0_selector, alu1_selector  out  4 each  bus mux selectors, registered.
- dst_we  out  11  one-hot destination write enable, bit n = destination index n, registered.
- done  out  1  one-cycle pulse, coincident with dst_we.
- err  out  1  one-cycle pulse: illegal request rejected.
- busy  out  1  high whenever FSM not IDLE or queue non-empty.

## Operation

- Queue: FIFO of {src, dst}. Push when req_valid && req_ready && both fields legal. Illegal src (≥12) or dst (≥11) with req_valid && req_ready: not queued; err pulses next cycle; no other effect.
- Simultaneous push and pop: count unchanged, both take effect. Push never occurs when full (req_ready low). No combinational pass-through: an entry pushed at edge k is poppable no earlier than edge k+1.
- FSM states: IDLE, DRIVE, WAIT, COMMIT.
  - IDLE: if queue non-empty and !stall, pop head, register the selected destination's selector ← src, then go to DRIVE. Otherwise stay in IDLE.
  - DRIVE: selector stable; mux samples it on this edge. Go to WAIT.
  - WAIT: mux output valid at the destination. Go to COMMIT.
  - COMMIT: dst_we[dst]=1 and done=1 for this cycle. Next state is DRIVE with the new head popped if the queue is non-empty (back-to-back); otherwise IDLE.
- Non-active selectors are always 0 (zero source). The active selector returns to 0 on the edge leaving COMMIT, unless the next entry reuses the same destination.
- stall high: the state and all registered outputs hold, except dst_we and done, which are forced 0 while stalled in COMMIT. Commit completes in the first unstalled COMMIT cycle. Pushes continue during stall.
- busy = (state≠IDLE) || (count≠0).

## Timing

- Reset (synchronous): state IDLE, queue empty, all selectors 4'h0, dst_we 0, done 0, err 0, busy 0, req_ready 1 (after the edge).
- Reset mid-transfer: the in-flight transfer and queued entries are discarded. No dst_we is issued after the reset edge. A request presented in the same cycle as reset is dropped.
- Latency, empty queue, no stall: push at edge 0 → pop/selector set at edge 1 → DRIVE cycle 1, WAIT cycle 2, COMMIT cycle 3 (dst_we high between edges 3 and 4).
- Throughput: one transfer per 3 cycles back-to-back.
- err asserts the cycle after the rejected handshake edge.

## Test plan

- Reset: assert reset 2 cycles mid-stream → all selectors 0, dst_we 0, busy 0, req_ready 1.
- Single transfer: push {src=4 (x), dst=0 (pc)} at edge 0 → pc_selector=4 during cycles 1–3, dst_we=11'b000_0000_0001 and done in cycle 3 only; all other selectors 0 throughout.
- Back-to-back and full queue: push 5 legal entries with DEPTH=4 and the FSM stalled → req_ready low after 4. Release stall → 4 commits at cycles spaced exactly 3 apart, in order; 5th accepted once space frees.
- Illegal: push src=13 then dst=11 → err pulses one cycle each; no queue entry, no dst_we, busy unaffected.
- Stall in COMMIT: {src=11, dst=9} with stall raised in COMMIT for 4 cycles → alu0_selector held at 11, dst_we 0 during stall, single dst_we[9] pulse in the first unstalled cycle.
- Reset during WAIT of {src=7, dst=6} with 2 entries queued → no dst_we, queue empty, mem_selector 0 after the reset edge.
